// File: rtl/phasecomp_axis_pkg.sv
// ============================================================================
// Module   : phasecomp_axis_pkg
// Purpose  : Shared types and helpers for the AXI-Stream phase compensator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package phasecomp_axis_pkg;

  localparam int FFT_LEN_DEF = 64;
  localparam int DEC_FAC_DEF = 48;
  localparam int WIDTH_DEF   = 16;

  typedef logic bank_t;

  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of distinct rotation offsets before the sequence repeats.
  function automatic int num_states(input int m, input int d);
    return m / gcd(m, d);
  endfunction

endpackage

`default_nettype wire

// File: rtl/phasecomp_axis_sdp_ram.sv
// ============================================================================
// Module   : phasecomp_axis_sdp_ram
// Purpose  : Simple dual-port RAM, one write port, registered read with enable.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phasecomp_axis_sdp_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/phasecomp_axis.sv
// ============================================================================
// Module   : phasecomp_axis
// Purpose  : Ping-pong frame buffer emitting each frame circularly rotated.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phasecomp_axis
  import phasecomp_axis_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int DEC_FAC = DEC_FAC_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [WIDTH-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  input  logic                       rot_en,
  output logic [$clog2(FFT_LEN)-1:0] shift_out,
  output logic                       frame_err
);

  localparam int AW = $clog2(FFT_LEN);

  typedef logic [WIDTH-1:0] sample_t;
  typedef logic [AW-1:0]    idx_t;
  typedef logic [AW:0]      wide_t;

  localparam idx_t  LAST_IDX = idx_t'(FFT_LEN - 1);
  localparam wide_t M_W      = wide_t'(FFT_LEN);
  localparam wide_t DEC_W    = wide_t'(DEC_FAC);

  logic [1:0] full_q, full_d;
  bank_t      wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  idx_t       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  idx_t       shift_q, shift_d;
  logic       rot_q, rot_d;
  logic       tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic       err_q, err_d;

  logic    w_wr_fire, w_rd_en, w_rot_eff, w_wr_last, w_rd_last;
  idx_t    w_eff_shift, w_rd_idx, w_shift_nxt;
  wide_t   w_shift_sum;
  sample_t w_rd_data;

  assign w_wr_fire   = s_axis_tvalid & ~full_q[wr_bank_q];
  assign w_rd_en     = full_q[rd_bank_q] & (~tvalid_q | m_axis_tready);
  assign w_wr_last   = (wr_cnt_q == LAST_IDX);
  assign w_rd_last   = (rd_cnt_q == LAST_IDX);
  // rot_en is sampled live on the first read of a frame, then held.
  assign w_rot_eff   = (rd_cnt_q == '0) ? rot_en : rot_q;
  assign w_eff_shift = w_rot_eff ? shift_q : '0;
  assign w_rd_idx    = rd_cnt_q + w_eff_shift;
  assign w_shift_sum = {1'b0, shift_q} + DEC_W;
  assign w_shift_nxt = (w_shift_sum >= M_W) ? idx_t'(w_shift_sum - M_W) : idx_t'(w_shift_sum);

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    shift_d   = shift_q;
    rot_d     = rot_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    err_d     = err_q;

    if (w_wr_fire) begin
      if (s_axis_tlast != w_wr_last) begin
        err_d = 1'b1;
      end
      if (w_wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (w_rd_en) begin
      tvalid_d = 1'b1;
      tlast_d  = w_rd_last;
      rot_d    = w_rot_eff;
      if (w_rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        shift_d           = w_shift_nxt;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      shift_q   <= '0;
      rot_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      shift_q   <= shift_d;
      rot_q     <= rot_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      err_q     <= err_d;
    end
  end

  phasecomp_axis_sdp_ram #(
    .DEPTH (2 * FFT_LEN),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_wr_fire & ~rst),
    .waddr_i ({wr_bank_q, wr_cnt_q}),
    .wdata_i (s_axis_tdata),
    .re_i    (w_rd_en & ~rst),
    .raddr_i ({rd_bank_q, w_rd_idx}),
    .rdata_o (w_rd_data)
  );

  assign s_axis_tready = ~full_q[wr_bank_q];
  assign m_axis_tdata  = w_rd_data;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign shift_out     = shift_q;
  assign frame_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_phasecomp_axis.sv
// ============================================================================
// Module   : tb_phasecomp_axis
// Purpose  : Scoreboard bench for phasecomp_axis (M=8/D=6 and M=16/D=12).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_phasecomp_axis;

  localparam int M1 = 8;
  localparam int D1 = 6;
  localparam int W1 = 16;
  localparam int M2 = 16;
  localparam int D2 = 12;
  localparam int W2 = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W1-1:0] s1_tdata = '0;
  logic          s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
  logic [W1-1:0] m1_tdata;
  logic          m1_tvalid, m1_tlast, m1_tready = 1'b1, rot1 = 1'b1;
  logic [2:0]    shift1;
  logic          err1;

  logic [W2-1:0] s2_tdata = '0;
  logic          s2_tvalid = 1'b0, s2_tlast = 1'b0, s2_tready;
  logic [W2-1:0] m2_tdata;
  logic          m2_tvalid, m2_tlast, m2_tready = 1'b1, rot2 = 1'b1;
  logic [3:0]    shift2;
  logic          err2;

  phasecomp_axis #(.FFT_LEN(M1), .DEC_FAC(D1), .WIDTH(W1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .s_axis_tlast(s1_tlast),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
    .m_axis_tlast(m1_tlast),
    .rot_en(rot1), .shift_out(shift1), .frame_err(err1)
  );

  phasecomp_axis #(.FFT_LEN(M2), .DEC_FAC(D2), .WIDTH(W2)) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .s_axis_tlast(s2_tlast),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
    .m_axis_tlast(m2_tlast),
    .rot_en(rot2), .shift_out(shift2), .frame_err(err2)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        chk_sh;
    logic [31:0] sh;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int          total = 0;
  int          bad = 0;
  int          k1 = 0;
  int          k2 = 0;
  bit          rand_rdy = 1'b0;
  bit          saw_stall = 1'b0;
  logic [31:0] fbuf [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: output n of frame k is input (n + k*D mod M) mod M.
  task automatic push_frame(input int dut, input bit rot);
    int   m;
    int   sh;
    exp_t e;
    m  = (dut == 1) ? M1 : M2;
    sh = (dut == 1) ? (k1 * D1) % M1 : (k2 * D2) % M2;
    for (int n = 0; n < m; n++) begin
      e.data   = fbuf[(n + (rot ? sh : 0)) % m];
      e.last   = (n == m - 1);
      e.chk_sh = (n == 0);
      e.sh     = 32'(sh);
      if (dut == 1) q1.push_back(e);
      else          q2.push_back(e);
    end
    if (dut == 1) k1++;
    else          k2++;
  endtask

  task automatic send1(input logic [31:0] data, input logic last);
    int guard = 0;
    s1_tdata  = data[W1-1:0];
    s1_tlast  = last;
    s1_tvalid = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!s1_tready && guard < 300);
    if (!s1_tready) check("dut1_in_accept_timeout", 32'(s1_tready), 32'd1);
    @(posedge clk);
    #1;
    s1_tvalid = 1'b0;
    s1_tlast  = 1'b0;
  endtask

  task automatic send2(input logic [31:0] data, input logic last);
    int guard = 0;
    s2_tdata  = data[W2-1:0];
    s2_tlast  = last;
    s2_tvalid = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!s2_tready && guard < 300);
    if (!s2_tready) check("dut2_in_accept_timeout", 32'(s2_tready), 32'd1);
    @(posedge clk);
    #1;
    s2_tvalid = 1'b0;
    s2_tlast  = 1'b0;
  endtask

  // base < 0 selects random data; lastpos is where tlast is driven.
  task automatic send_frame1(input bit rot, input int base, input int lastpos,
                             input int nsamp, input bit chk_err);
    rot1 = rot;
    for (int n = 0; n < M1; n++) begin
      fbuf[n] = (base < 0) ? ($urandom & 32'hFFFF) : 32'(base + n);
    end
    for (int n = 0; n < nsamp; n++) begin
      send1(fbuf[n], n == lastpos);
      if (chk_err) check("frame_err_during_frame", 32'(err1), 32'(n >= lastpos));
    end
    if (nsamp == M1) push_frame(1, rot);
  endtask

  task automatic send_frame2();
    for (int n = 0; n < M2; n++) fbuf[n] = $urandom & 32'hFF_FFFF;
    for (int n = 0; n < M2; n++) send2(fbuf[n], n == M2 - 1);
    push_frame(2, 1'b1);
  endtask

  task automatic drain(input int dut);
    int guard = 0;
    while (((dut == 1) ? q1.size() : q2.size()) != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check((dut == 1) ? "dut1_drain_left" : "dut2_drain_left",
          32'((dut == 1) ? q1.size() : q2.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check((dut == 1) ? "dut1_idle_tvalid" : "dut2_idle_tvalid",
          32'((dut == 1) ? m1_tvalid : m2_tvalid), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s1_tvalid = 1'b0;
    s2_tvalid = 1'b0;
    q1.delete();
    q2.delete();
    k1 = 0;
    k2 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_state1(input string tag);
    check({tag, "_tvalid"}, 32'(m1_tvalid), 32'd0);
    check({tag, "_tlast"},  32'(m1_tlast),  32'd0);
    check({tag, "_tdata"},  32'(m1_tdata),  32'd0);
    check({tag, "_shift"},  32'(shift1),    32'd0);
    check({tag, "_err"},    32'(err1),      32'd0);
    check({tag, "_tready"}, 32'(s1_tready), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && m1_tvalid && m1_tready) begin
      if (q1.size() == 0) begin
        check("dut1_extra_output", 32'(q1.size()), 32'd1);
      end else begin
        e = q1.pop_front();
        check("dut1_data", 32'(m1_tdata), e.data);
        check("dut1_tlast", 32'(m1_tlast), 32'(e.last));
        if (e.chk_sh) check("dut1_shift_out", 32'(shift1), e.sh);
      end
    end
    if (!rst && s1_tvalid && !s1_tready) saw_stall = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && m2_tvalid && m2_tready) begin
      if (q2.size() == 0) begin
        check("dut2_extra_output", 32'(q2.size()), 32'd1);
      end else begin
        e = q2.pop_front();
        check("dut2_data", 32'(m2_tdata), e.data);
        check("dut2_tlast", 32'(m2_tlast), 32'(e.last));
        if (e.chk_sh) check("dut2_shift_out", 32'(shift2), e.sh);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m1_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state1("reset");

    // Continuous stream, 16k+n pattern, with first-output latency check.
    send_frame1(1'b1, 0, M1 - 1, M1, 1'b0);
    check("latency_tvalid_at_t", 32'(m1_tvalid), 32'd0);
    @(negedge clk);
    check("latency_tvalid_before_t1", 32'(m1_tvalid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_tvalid_after_t1", 32'(m1_tvalid), 32'd1);
    for (int k = 1; k < 16; k++) send_frame1(1'b1, 16 * k, M1 - 1, M1, 1'b0);
    drain(1);
    check("stream_frame_err", 32'(err1), 32'd0);

    // Rotation disabled for frames 1-2; the offset still advances.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_frame1(!(k == 1 || k == 2), -1, M1 - 1, M1, 1'b0);
      drain(1);
    end

    // Random output backpressure with input always valid.
    do_reset();
    saw_stall = 1'b0;
    rand_rdy  = 1'b1;
    for (int k = 0; k < 8; k++) send_frame1(1'b1, -1, M1 - 1, M1, 1'b0);
    rand_rdy = 1'b0;
    drain(1);
    check("backpressure_saw_stall", 32'(saw_stall), 32'd1);

    // Misplaced tlast in frame 0: sticky error, data unaffected.
    do_reset();
    check("err_before", 32'(err1), 32'd0);
    send_frame1(1'b1, -1, 5, M1, 1'b1);
    send_frame1(1'b1, -1, M1 - 1, M1, 1'b0);
    drain(1);
    check("err_sticky", 32'(err1), 32'd1);

    // Reset in the middle of frame 2 discards everything buffered.
    do_reset();
    send_frame1(1'b1, -1, M1 - 1, M1, 1'b0);
    send_frame1(1'b1, -1, M1 - 1, M1, 1'b0);
    send_frame1(1'b1, -1, M1 - 1, 3, 1'b0);
    do_reset();
    check_reset_state1("midreset");
    @(posedge clk);
    #1;
    check("midreset_idle_tvalid", 32'(m1_tvalid), 32'd0);
    send_frame1(1'b1, -1, M1 - 1, M1, 1'b0);
    drain(1);

    // M=16, D=12, WIDTH=24: offsets 0,12,8,4,0.
    for (int k = 0; k < 5; k++) send_frame2();
    drain(2);
    check("dut2_frame_err", 32'(err2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/phasecomp_axis.md
Name: phasecomp_axis

Overview:
- AXI-Stream successor to the oversampled-PFB phase compensator. Sits between the polyphase FIR and the FFT.
- Buffers each M-sample frame in a ping-pong RAM and emits it circularly rotated by a per-frame offset that advances by D modulo M.
- Adds tvalid/tready backpressure, tlast framing and a frame-error flag.
- Adds a runtime rotation enable and parametrised M/D/width, none of which the previous free-running PhaseComp had.

Parameters:
- FFT_LEN, 64, frame length M, in samples (power of 2, ≥4).
- DEC_FAC, 48, decimation factor D, added to the offset each frame (1 ≤ D ≤ M).
- WIDTH, 16, sample width in bits; data is treated as opaque.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  WIDTH  input sample, processing order
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  expected on sample M-1 of each frame
- m_axis_tdata  out  WIDTH  rotated sample
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  high on output sample M-1
- rot_en  in  1  1 = rotate; 0 = pass frame unrotated
- shift_out  out  $clog2(FFT_LEN)  offset applied to the frame currently being read
- frame_err  out  1  sticky tlast-mismatch flag

Behaviour:
- Reset (rst=1 at a posedge):
  - both banks empty; wr_bank=rd_bank=0; wr_cnt=rd_cnt=0
  - shift=0; shift_out=0
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0; frame_err=0
  - s_axis_tready=1 from the first cycle after reset
  - reset mid-frame discards all buffered data; RAM contents are not cleared.
- Write side:
  - s_axis_tready = ~full[wr_bank].
  - A transfer (valid&ready) writes addr wr_bank*M + wr_cnt, then wr_cnt increments.
  - At wr_cnt=M-1 the transfer sets full[wr_bank], toggles wr_bank and clears wr_cnt.
  - Framing is set by the counter only; tlast does not delimit frames.
  - frame_err sets when tlast=1 with wr_cnt≠M-1, or tlast=0 with wr_cnt=M-1. It clears only on reset.
- Read side:
  - rd_en = full[rd_bank] & (~m_axis_tvalid | m_axis_tready).
  - On rd_en:
    - RAM reads addr rd_bank*M + ((rd_cnt + eff_shift) mod M).
    - The 1-cycle synchronous read lands in the output register, m_axis_tvalid=1.
    - m_axis_tlast = (rd_cnt==M-1); rd_cnt increments.
  - eff_shift = shift when the latched rot_en is 1, else 0.
  - rot_en is latched when rd_cnt==0 and rd_en=1, and held for the whole frame.
  - On the read with rd_cnt=M-1:
    - clear full[rd_bank] and toggle rd_bank
    - shift <= (shift + DEC_FAC) mod M; this advance happens even when rot_en=0, so phase stays aligned
    - rd_cnt <= 0
  - m_axis_tvalid drops when the output is consumed and rd_en=0.
  - Output register holds data/tlast stable while tvalid&~tready.
- Offset sequence: shift_k = (k·D) mod M, cycling through M/gcd(M,D) states. Output n of frame k = input ((n + shift_k) mod M) of frame k.
- Latency and throughput:
  - The last input of frame k is accepted at edge t; full is set at t; the first read happens at edge t+1; m_axis_tvalid=1 after t+1.
  - With tready held high, this sustains 1 sample/clk indefinitely.
- Boundary cases:
  - Both banks full → s_axis_tready=0 until the reader frees a bank.
  - Write-complete and read-complete on the same edge touch different banks; both take effect.
  - Writing a bank whose last sample is being read that cycle is impossible, because full clears at the same edge as the read.
  - Offset wrap uses subtract-if-≥M; no modulo hardware is needed for D ≤ M.

Decomposition:
- alpaca_ospfb_constants_pkg supplies FFT_LEN and DEC_FAC.
- alpaca_ospfb_ix_pkg gains gcd(), NUM_STATES, and the typedefs sample_t (logic [WIDTH-1:0]), idx_t (logic [$clog2(FFT_LEN)-1:0]) and bank_t.
- One sub-module: sdp_ram, a simple dual-port RAM with DEPTH=2·FFT_LEN, WIDTH, one write port and a registered 1-cycle read port with read-enable.

Test Plan (M=8, D=6 unless noted):
- Continuous stream, tready=1, frame k data = 16k+n → outputs:
  - frame0 0x00..0x07
  - frame1 0x16,0x17,0x10..0x15
  - frame2 0x24..0x27,0x20..0x23
  - frame3 0x32..0x37,0x30,0x31
  - frame4 unrotated
  - first tvalid 1 cycle after the edge accepting input 7
  - zero errors over 16 frames
- rot_en=0 for frames 1–2, then 1 → frames 1–2 unrotated; frame3 still uses shift 2; shift_out reads 6,4,2.
- m_axis_tready toggled 50% random, input always valid → s_axis_tready drops when both banks are full; output order identical to the first case; no sample lost or duplicated.
- tlast asserted on input sample 5 of frame 0 → frame_err=1 from the next cycle, stays 1; data path unaffected.
- rst pulsed after 3 samples of frame 2 → outputs idle with tvalid=0; next frame's output uses shift 0.
- M=16, D=12, WIDTH=24 → shifts 0,12,8,4,0 with correct rotated data.
